// File: rtl/uart_resp_arbiter.sv
// Round-robin arbiter sharing one UART response transmitter among NUM_REQ sources.
// Latches a byte, pulses trmt once, waits for tx_done rising edge or watchdog timeout.
module uart_resp_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 40000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [8*NUM_REQ-1:0]       req_data,
   input  logic                       tx_done,
   output logic                       trmt,
   output logic [7:0]                 resp,
   output logic [NUM_REQ-1:0]         ack,
   output logic [NUM_REQ-1:0]         done,
   output logic                       tx_err,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] cur_id
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int CW  = $clog2(TIMEOUT_CYC);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;

   logic [1:0]     state;
   logic [IDW-1:0] last;
   logic [CW-1:0]  tmo_cnt;
   logic           tx_done_q;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           tx_rise;
   logic           tmo_hit;

   assign tx_rise = tx_done & ~tx_done_q;
   assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYC - 1));

   // Search starts just past the last grant so every waiting requester gets a turn.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      grant_valid = 1'b0;
      grant_id    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!grant_valid && req[(int'(last) + k) % NUM_REQ]) begin
            grant_valid = 1'b1;
            grant_id    = IDW'((int'(last) + k) % NUM_REQ);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers
   // update together on the edge regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         last      <= IDW'(NUM_REQ - 1);
         cur_id    <= '0;
         resp      <= 8'h00;
         tmo_cnt   <= '0;
         tx_done_q <= 1'b0;
      end else begin
         tx_done_q <= tx_done;
         case (state)
            S_IDLE: begin
               if (grant_valid) begin
                  cur_id <= grant_id;
                  resp   <= req_data[{grant_id, 3'b000} +: 8];
                  state  <= S_SEND;
               end
            end
            S_SEND: begin
               tmo_cnt <= '0;
               state   <= S_BUSY;
            end
            S_BUSY: begin
               // Completion takes precedence over a coincident timeout.
               if (tx_rise || tmo_hit) begin
                  last  <= cur_id;
                  state <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign trmt   = (state == S_SEND);
   assign busy   = (state != S_IDLE);
   assign ack    = trmt ? (NUM_REQ'(1) << cur_id) : '0;
   assign done   = ((state == S_BUSY) && tx_rise) ? (NUM_REQ'(1) << cur_id) : '0;
   assign tx_err = (state == S_BUSY) && !tx_rise && tmo_hit;

endmodule

// File: tb/tb_uart_resp_arbiter.sv
// Self-checking bench for uart_resp_arbiter: vector table, directed sequences,
// and randomized traffic against a transaction-level reference model.
module tb_uart_resp_arbiter;

   localparam int NR  = 4;
   localparam int TMO = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NR-1:0] req;
   logic [31:0]   req_data;
   logic          tx_done;
   logic          trmt;
   logic [7:0]    resp;
   logic [NR-1:0] ack;
   logic [NR-1:0] done;
   logic          tx_err;
   logic          busy;
   logic [1:0]    cur_id;

   int checks   = 0;
   int failures = 0;

   uart_resp_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .tx_done(tx_done),
      .trmt(trmt), .resp(resp), .ack(ack), .done(done), .tx_err(tx_err),
      .busy(busy), .cur_id(cur_id)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pk(input logic t, input logic [3:0] a, input logic [3:0] d,
                                      input logic e, input logic b, input logic [1:0] c,
                                      input logic [7:0] r);
      return {11'b0, t, a, d, e, b, c, r};
   endfunction

   function automatic logic [31:0] obs();
      return pk(trmt, ack, done, tx_err, busy, cur_id, resp);
   endfunction

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic        txd;
      int          n;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[12];

   task automatic wait_trmt(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 80; c++) begin
         #1;
         if (trmt === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   // One full grant: expect exp_id, finish it with a tx_done edge, then apply next_req.
   task automatic serve(input int exp_id, input logic [3:0] next_req, input string name);
      bit ok;
      wait_trmt(ok);
      if (!ok) begin
         check({name, "_no_trmt"}, 32'd0, 32'd1);
         return;
      end
      check({name, "_cur_id"}, 32'(cur_id), 32'(exp_id));
      check({name, "_ack"}, 32'(ack), 32'(4'b1 << exp_id));
      check({name, "_resp"}, 32'(resp), 32'(req_data[8*exp_id +: 8]));
      tick();
      tick();
      tx_done = 1'b1;
      req     = next_req;
      #1;
      check({name, "_done"}, 32'(done), 32'(4'b1 << exp_id));
      check({name, "_busy_on_done"}, 32'(busy), 32'd1);
      tick();
      tx_done = 1'b0;
      #1;
      check({name, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   // Reference model: transaction-level view of one grant at a time.
   typedef enum {M_IDLE, M_SEND, M_BUSY} mphase_t;
   mphase_t    m_phase;
   int         m_last, m_cur, m_bc;
   logic [7:0] m_resp;
   logic       m_tdq;

   function automatic int rr_pick(input int last, input logic [3:0] r);
      for (int off = 1; off <= NR; off++) begin
         int id;
         id = (last + off) % NR;
         if (r[id]) return id;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = M_IDLE;
      m_last  = NR - 1;
      m_cur   = 0;
      m_bc    = 0;
      m_resp  = 8'h00;
      m_tdq   = 1'b0;
   endtask

   function automatic logic [31:0] model_out();
      logic edge_seen;
      logic [3:0] oh;
      edge_seen = tx_done && !m_tdq;
      oh = 4'b1 << m_cur;
      return pk(m_phase == M_SEND, (m_phase == M_SEND) ? oh : 4'b0,
                (m_phase == M_BUSY && edge_seen) ? oh : 4'b0,
                m_phase == M_BUSY && !edge_seen && m_bc == TMO,
                m_phase != M_IDLE, 2'(m_cur), m_resp);
   endfunction

   task automatic model_step();
      logic edge_seen;
      int   pick;
      edge_seen = tx_done && !m_tdq;
      m_tdq = tx_done;
      case (m_phase)
         M_IDLE: begin
            pick = rr_pick(m_last, req);
            if (pick >= 0) begin
               m_cur   = pick;
               m_resp  = req_data[8*pick +: 8];
               m_phase = M_SEND;
            end
         end
         M_SEND: begin
            m_bc    = 1;
            m_phase = M_BUSY;
         end
         default: begin
            if (edge_seen || m_bc == TMO) begin
               m_last  = m_cur;
               m_phase = M_IDLE;
            end else begin
               m_bc++;
            end
         end
      endcase
   endtask

   initial begin
      bit ok;
      rst_n    = 1'b0;
      req      = '0;
      req_data = '0;
      tx_done  = 1'b0;
      #3;
      check("reset_outputs", obs(), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Single requester with a late edge, then tx_done already high on BUSY entry.
      tbl[0]  = '{4'b0000, 32'h0000_0000, 1'b0, 2,  pk(0, 4'b0000, 4'b0000, 0, 0, 2'd0, 8'h00)};
      tbl[1]  = '{4'b0100, 32'h00A5_0000, 1'b0, 1,  pk(0, 4'b0000, 4'b0000, 0, 0, 2'd0, 8'h00)};
      tbl[2]  = '{4'b0100, 32'h00A5_0000, 1'b0, 1,  pk(1, 4'b0100, 4'b0000, 0, 1, 2'd2, 8'hA5)};
      tbl[3]  = '{4'b0000, 32'h0000_0000, 1'b0, 19, pk(0, 4'b0000, 4'b0000, 0, 1, 2'd2, 8'hA5)};
      tbl[4]  = '{4'b0000, 32'h0000_0000, 1'b1, 1,  pk(0, 4'b0000, 4'b0100, 0, 1, 2'd2, 8'hA5)};
      tbl[5]  = '{4'b0000, 32'h0000_0000, 1'b1, 3,  pk(0, 4'b0000, 4'b0000, 0, 0, 2'd2, 8'hA5)};
      tbl[6]  = '{4'b0001, 32'h0000_003C, 1'b1, 1,  pk(0, 4'b0000, 4'b0000, 0, 0, 2'd2, 8'hA5)};
      tbl[7]  = '{4'b0001, 32'h0000_003C, 1'b1, 1,  pk(1, 4'b0001, 4'b0000, 0, 1, 2'd0, 8'h3C)};
      tbl[8]  = '{4'b0000, 32'h0000_0000, 1'b1, 1,  pk(0, 4'b0000, 4'b0000, 0, 1, 2'd0, 8'h3C)};
      tbl[9]  = '{4'b0000, 32'h0000_0000, 1'b0, 29, pk(0, 4'b0000, 4'b0000, 0, 1, 2'd0, 8'h3C)};
      tbl[10] = '{4'b0000, 32'h0000_0000, 1'b1, 1,  pk(0, 4'b0000, 4'b0001, 0, 1, 2'd0, 8'h3C)};
      tbl[11] = '{4'b0000, 32'h0000_0000, 1'b0, 2,  pk(0, 4'b0000, 4'b0000, 0, 0, 2'd0, 8'h3C)};

      for (int v = 0; v < 12; v++) begin
         for (int c = 0; c < tbl[v].n; c++) begin
            req      = tbl[v].req;
            req_data = tbl[v].data;
            tx_done  = tbl[v].txd;
            #1;
            check($sformatf("vec%0d_cyc%0d", v, c), obs(), tbl[v].exp);
            tick();
         end
      end

      // All four held continuously: 0,1,2,3,0,1; then only 1 and 3 with last=1.
      rst_n = 1'b0;
      #1;
      check("reset_again", obs(), 32'd0);
      tick();
      rst_n    = 1'b1;
      req      = 4'b1111;
      req_data = 32'h44_33_22_11;
      serve(0, 4'b1111, "rr0");
      serve(1, 4'b1111, "rr1");
      serve(2, 4'b1111, "rr2");
      serve(3, 4'b1111, "rr3");
      serve(0, 4'b1111, "rr4");
      serve(1, 4'b1010, "rr5");
      serve(3, 4'b1010, "pair3");
      serve(1, 4'b1010, "pair1");
      serve(3, 4'b0101, "pair3b");

      // Watchdog: tx_done never rises for requester 0; requester 2 is next.
      wait_trmt(ok);
      check("tmo_grant", 32'(ok ? cur_id : 2'd3), 32'd0);
      req = 4'b0100;
      tick();
      for (int k = 1; k <= TMO; k++) begin
         #1;
         check($sformatf("tmo_k%0d", k), {30'b0, |done, tx_err}, (k == TMO) ? 32'd1 : 32'd0);
         tick();
      end
      #1;
      check("tmo_idle", 32'(busy), 32'd0);
      serve(2, 4'b0010, "after_tmo");

      // Asynchronous reset in the middle of BUSY.
      wait_trmt(ok);
      check("rst_mid_grant", 32'(ok ? cur_id : 2'd3), 32'd1);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", obs(), 32'd0);
      tick();
      req   = 4'b0011;
      tick();
      rst_n = 1'b1;
      serve(0, 4'b0000, "post_rst");

      // Randomized traffic against the reference model.
      rst_n = 1'b0;
      req   = '0;
      tick();
      rst_n = 1'b1;
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic [31:0] exp_v;
         logic [3:0]  acked;
         acked = (m_phase == M_SEND) ? (4'b1 << m_cur) : 4'b0;
         if ($urandom_range(0, 9) == 0) tx_done = ~tx_done;
         for (int i = 0; i < NR; i++) begin
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  req_data[8*i +: 8] = 8'($urandom);
               end
            end else if (acked[i]) begin
               if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
               else req_data[8*i +: 8] = 8'($urandom);
            end
         end
         #1;
         exp_v = model_out();
         check($sformatf("rand_cyc%0d", cyc), obs(), exp_v);
         model_step();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
